// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the ssdram controller port among video fetch, the
// Z80 CPU and the ROM/tape loader. Each granted access holds the strobes
// for LAT cycles. The arbiter then pulses a one-cycle ack to the winner
// and returns to IDLE.
module sdram_arbiter #(
   parameter int AW       = 18,
   parameter int LAT      = 4,
   parameter int VID_PRIO = 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic [7:0]    vid_rdata,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_wdata,
   output logic          cpu_ack,
   output logic [7:0]    cpu_rdata,
   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   input  logic [7:0]    ld_wdata,
   output logic          ld_ack,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata,
   output logic          mem_cs,
   output logic          mem_oe,
   output logic          mem_we,
   output logic          busy
);

   localparam int CW = $clog2(LAT);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic [1:0] {SRC_VID, SRC_CPU, SRC_LD} src_t;

   state_t        state;
   src_t          owner;
   src_t          rr_ptr;
   logic [CW-1:0] counter;

   logic          any_req;
   src_t          pick;
   src_t          ptr_next;
   logic [AW-1:0] sel_addr;
   logic [7:0]    sel_wdata;
   logic          sel_we;

   // Winner selection from the live requests and the round-robin pointer.
   always_comb begin
      any_req = vid_req | cpu_req | ld_req;
      pick    = SRC_CPU;
      if (VID_PRIO != 0) begin
         // Video pre-empts; CPU and loader share the pointer only on a tie.
         if (vid_req)
            pick = SRC_VID;
         else if (cpu_req && ld_req)
            pick = (rr_ptr == SRC_LD) ? SRC_LD : SRC_CPU;
         else if (cpu_req)
            pick = SRC_CPU;
         else
            pick = SRC_LD;
      end else begin
         case (rr_ptr)
            SRC_VID: pick = vid_req ? SRC_VID : (cpu_req ? SRC_CPU : SRC_LD);
            SRC_CPU: pick = cpu_req ? SRC_CPU : (ld_req  ? SRC_LD  : SRC_VID);
            default: pick = ld_req  ? SRC_LD  : (vid_req ? SRC_VID : SRC_CPU);
         endcase
      end
   end

   // Pointer after serving the current pick: always moves past the winner.
   always_comb begin
      ptr_next = rr_ptr;
      if (VID_PRIO != 0) begin
         if (pick == SRC_CPU)
            ptr_next = SRC_LD;
         else if (pick == SRC_LD)
            ptr_next = SRC_CPU;
      end else begin
         case (pick)
            SRC_VID: ptr_next = SRC_CPU;
            SRC_CPU: ptr_next = SRC_LD;
            default: ptr_next = SRC_VID;
         endcase
      end
   end

   // Request fields of the selected requester; video is read-only, loader write-only.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      case (pick)
         SRC_VID: begin
            sel_addr = vid_addr;
         end
         SRC_CPU: begin
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
            sel_we    = cpu_we;
         end
         default: begin
            sel_addr  = ld_addr;
            sel_wdata = ld_wdata;
            sel_we    = 1'b1;
         end
      endcase
   end

   // Access FSM with registered strobes, acks and read-data capture.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         owner     <= SRC_CPU;
         rr_ptr    <= SRC_CPU;
         counter   <= '0;
         vid_ack   <= 1'b0;
         cpu_ack   <= 1'b0;
         ld_ack    <= 1'b0;
         vid_rdata <= '0;
         cpu_rdata <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_cs    <= 1'b0;
         mem_oe    <= 1'b0;
         mem_we    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner     <= pick;
                  rr_ptr    <= ptr_next;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_we    <= sel_we;
                  mem_oe    <= ~sel_we;
                  mem_cs    <= 1'b1;
                  counter   <= CW'(LAT - 1);
                  busy      <= 1'b1;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (counter == '0) begin
                  mem_cs <= 1'b0;
                  mem_oe <= 1'b0;
                  mem_we <= 1'b0;
                  case (owner)
                     SRC_VID: begin
                        vid_ack   <= 1'b1;
                        vid_rdata <= mem_rdata;
                     end
                     SRC_CPU: begin
                        cpu_ack <= 1'b1;
                        if (mem_oe)
                           cpu_rdata <= mem_rdata;
                     end
                     default: ld_ack <= 1'b1;
                  endcase
                  state <= DONE;
               end else begin
                  counter <= counter - 1'b1;
               end
            end
            DONE: begin
               vid_ack <= 1'b0;
               cpu_ack <= 1'b0;
               ld_ack  <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios followed by randomized traffic. Every
// cycle is checked against a transaction-level model of the arbiter. The
// model derives strobe/ack timing from the grant edge arithmetically.
module tb_sdram_arbiter;

   localparam int AW       = 18;
   localparam int LAT      = 4;
   localparam int VID_PRIO = 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [2:0]    rq;
   logic [AW-1:0] a_vid, a_cpu, a_ld;
   logic          cpu_we;
   logic [7:0]    d_cpu, d_ld;
   logic [7:0]    mrd;

   logic          vid_ack, cpu_ack, ld_ack;
   logic [7:0]    vid_rdata, cpu_rdata;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_cs, mem_oe, mem_we, busy;

   sdram_arbiter #(.AW(AW), .LAT(LAT), .VID_PRIO(VID_PRIO)) dut (
      .clock     (clk),
      .reset_n   (reset_n),
      .vid_req   (rq[0]),
      .vid_addr  (a_vid),
      .vid_ack   (vid_ack),
      .vid_rdata (vid_rdata),
      .cpu_req   (rq[1]),
      .cpu_we    (cpu_we),
      .cpu_addr  (a_cpu),
      .cpu_wdata (d_cpu),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .ld_req    (rq[2]),
      .ld_addr   (a_ld),
      .ld_wdata  (d_ld),
      .ld_ack    (ld_ack),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mrd),
      .mem_cs    (mem_cs),
      .mem_oe    (mem_oe),
      .mem_we    (mem_we),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int          cyc    = 0;

   // Reference model: one outstanding transaction described by its grant edge.
   bit            m_active;
   bit            m_rst;
   int            m_g;
   int            m_win;
   int            m_ptr;
   bit            m_we;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_wd;
   logic [7:0]    m_vrd, m_crd;
   logic [2:0]    exp_ack;
   bit            exp_on;

   bit            rand_mode = 0;
   logic [2:0]    rearm     = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_edge();
      int k;
      int w;
      m_rst = !reset_n;
      if (!reset_n) begin
         m_active = 0;
         m_ptr    = 1;
         m_vrd    = '0;
         m_crd    = '0;
         m_addr   = '0;
         m_wd     = '0;
      end else if (m_active) begin
         k = cyc - m_g;
         if (k == LAT && !m_we) begin
            if (m_win == 0) m_vrd = mrd;
            if (m_win == 1) m_crd = mrd;
         end
         if (k == LAT + 1) m_active = 0;
      end else if (rq != 3'b000) begin
         w = -1;
         if (VID_PRIO != 0 && rq[0]) w = 0;
         for (int i = 0; i < 3 && w < 0; i++) begin
            int c;
            c = (m_ptr + i) % 3;
            if (!(VID_PRIO != 0 && c == 0) && rq[c]) w = c;
         end
         m_win    = w;
         m_g      = cyc;
         m_active = 1;
         case (w)
            0:       begin m_addr = a_vid; m_we = 0;      m_wd = m_wd;  end
            1:       begin m_addr = a_cpu; m_we = cpu_we; m_wd = d_cpu; end
            default: begin m_addr = a_ld;  m_we = 1;      m_wd = d_ld;  end
         endcase
         if (VID_PRIO != 0) begin
            if (w != 0) m_ptr = (w == 1) ? 2 : 1;
         end else begin
            m_ptr = (w + 1) % 3;
         end
      end
      exp_on  = m_active && (cyc - m_g) < LAT;
      exp_ack = (m_active && (cyc - m_g) == LAT) ? 3'(1 << m_win) : 3'b000;
   endtask

   task automatic compare();
      chk("ack",  {29'd0, ld_ack, cpu_ack, vid_ack}, {29'd0, exp_ack});
      chk("cs",   32'(mem_cs), 32'(exp_on));
      chk("oe",   32'(mem_oe), 32'(exp_on && !m_we));
      chk("we",   32'(mem_we), 32'(exp_on && m_we));
      chk("busy", 32'(busy),   32'(m_active));
      chk("vid_rdata", 32'(vid_rdata), 32'(m_vrd));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_crd));
      if (exp_on || m_rst)
         chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      if ((exp_on && m_we) || m_rst)
         chk("mem_wdata", 32'(mem_wdata), 32'(m_rst ? 8'h00 : m_wd));
   endtask

   // Requester agents: drop req the cycle after the ack, optionally re-raise.
   task automatic update_agents();
      for (int s = 0; s < 3; s++) begin
         if (exp_ack[s]) begin
            rq[s] = 1'b0;
         end else if (!rq[s]) begin
            if (rearm[s]) rq[s] = 1'b1;
            else if (rand_mode && $urandom_range(0, 3) == 0) rq[s] = 1'b1;
         end else if (rand_mode && m_active && m_win == s &&
                      (cyc - m_g) < LAT && $urandom_range(0, 39) == 0) begin
            rq[s] = 1'b0;
         end
      end
      if (rand_mode) begin
         a_vid   = AW'($urandom);
         a_cpu   = AW'($urandom);
         a_ld    = AW'($urandom);
         d_cpu   = 8'($urandom);
         d_ld    = 8'($urandom);
         cpu_we  = 1'($urandom);
         mrd     = 8'($urandom);
         reset_n = ($urandom_range(0, 299) != 0);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc++;
         model_edge();
         #1;
         compare();
         update_agents();
      end
   endtask

   initial begin
      reset_n = 1'b0;
      rq      = '0;
      a_vid   = '0;
      a_cpu   = '0;
      a_ld    = '0;
      cpu_we  = 1'b0;
      d_cpu   = '0;
      d_ld    = '0;
      mrd     = '0;
      step(2);
      reset_n = 1'b1;
      step(2);

      // Single CPU read
      a_cpu  = AW'(18'h01234);
      cpu_we = 1'b0;
      mrd    = 8'hA5;
      rq[1]  = 1'b1;
      step(8);
      chk("cpu_read_a5", 32'(cpu_rdata), 32'h0000_00A5);

      // All three requesters at the same edge
      a_vid = AW'(18'h00111);
      a_cpu = AW'(18'h02222);
      a_ld  = AW'(18'h03333);
      d_ld  = 8'h5A;
      mrd   = 8'h77;
      rq    = 3'b111;
      step(24);

      // Continuous CPU and loader traffic, video rises mid-sequence
      rearm = 3'b110;
      rq    = 3'b110;
      step(20);
      rq[0] = 1'b1;
      step(30);
      rearm = '0;
      step(16);

      // CPU write to the top address
      a_cpu  = AW'(18'h3FFFF);
      cpu_we = 1'b1;
      d_cpu  = 8'h3C;
      rq[1]  = 1'b1;
      step(8);

      // Requester drops during the access window
      cpu_we = 1'b0;
      mrd    = 8'hC3;
      rq[1]  = 1'b1;
      step(1);
      rq[1] = 1'b0;
      step(10);

      // Reset in the middle of an access, request still pending afterwards
      rq[2] = 1'b1;
      step(3);
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      step(10);

      // Randomized traffic
      rand_mode = 1;
      step(3000);
      rand_mode = 0;
      reset_n   = 1'b1;
      rq        = '0;
      step(12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
